// File: rtl/pipe_skid_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// Elastic pipeline-stage register with a valid/ready handshake. It sits
// between core pipeline stages (IF_ID, ID_EX, EX_MEM, MEM_WB) so that a stall
// from a multi-cycle unit propagates one stage at a time instead of through a
// global enable.
//
// SKID=1 : two entries (main + skid). in_ready comes straight from a flop, so
//          there is no combinational path from out_ready to in_ready.
// SKID=0 : one entry. in_ready = ~main_valid | out_ready (combinational).
//
// A synchronous flush empties the stage and discards any same-cycle accept.
// drop_cnt counts, with saturation, how many entries each flush threw away.
//
// Ports
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-high reset
//   flush      in   synchronous kill of held entries and same-cycle accept
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage can accept this cycle
//   in_data    in   [WIDTH-1:0] upstream payload
//   out_valid  out  out_data is valid
//   out_ready  in   downstream consumes this cycle
//   out_data   out  [WIDTH-1:0] head payload (main entry)
//   occupancy  out  [1:0] number of held entries (0..2)
//   drop_cnt   out  [CNT_W-1:0] saturating count of flushed entries
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  // The state encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_p1;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_data_p1;
  logic [WIDTH-1:0] skid_data_p1;
  logic             ready_p1;
  logic [CNT_W-1:0] drop_cnt_p1;

  logic             accept;
  logic             drain;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;
  logic [1:0]       drop_inc;

  // Saturating add of a small increment; the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    if (sum > {1'b0, {CNT_W{1'b1}}})
      sat_add = {CNT_W{1'b1}};
    else
      sat_add = sum[CNT_W-1:0];
  endfunction

  assign out_valid = (state_p1 != EMPTY);
  assign out_data  = main_data_p1;
  assign occupancy = state_p1;
  assign drop_cnt  = drop_cnt_p1;

  // With SKID=1 the ready flop mirrors "not full"; with SKID=0 the single
  // entry may be refilled in the same cycle it drains.
  assign in_ready = (SKID != 0) ? ready_p1 : ((state_p1 == EMPTY) | out_ready);

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Entries lost to a flush: those held, minus one leaving downstream, plus
  // one arriving this cycle. The result is always in 0..2.
  assign drop_inc = state_p1 + {1'b0, accept} - {1'b0, drain};

  always_comb begin
    state_nxt      = state_p1;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            // Only reachable with SKID=1: downstream stalled, park in skid.
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so the only event is a drain.
          if (drain) begin
            state_nxt      = ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---- stage boundary: control registers ----
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_p1    <= EMPTY;
      ready_p1    <= 1'b1;
      drop_cnt_p1 <= '0;
    end else begin
      state_p1 <= state_nxt;
      ready_p1 <= (state_nxt != TWO);
      if (flush)
        drop_cnt_p1 <= sat_add(drop_cnt_p1, drop_inc);
    end
  end

  // ---- stage boundary: payload registers ----
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      main_data_p1 <= '0;
      skid_data_p1 <= '0;
    end else begin
      if (load_main)
        main_data_p1 <= in_data;
      else if (main_from_skid)
        main_data_p1 <= skid_data_p1;
      if (load_skid)
        skid_data_p1 <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
`timescale 1ns/1ps
module tb_pipe_skid_stage;

  // Instance 0: SKID=1, CNT_W=8. Instance 1: SKID=0, CNT_W=8.
  // Instance 2: SKID=1, CNT_W=2 (saturation).
  logic        clk = 1'b0;
  logic        clr;
  logic        iv   [3];
  logic        ordy [3];
  logic        fl   [3];
  logic [31:0] din  [3];
  logic        irdy [3];
  logic        ovld [3];
  logic [31:0] dout [3];
  logic [1:0]  occ  [3];
  logic [7:0]  dc0;
  logic [7:0]  dc1;
  logic [1:0]  dc2;

  int total = 0;
  int bad   = 0;

  // Reference model: a bounded FIFO per instance plus a drop counter.
  int          mn [3];
  logic [31:0] md [3][2];
  int          mc [3];

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(32), .SKID(1), .CNT_W(8)) u0 (
    .clock(clk), .clear(clr), .flush(fl[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_data(din[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_data(dout[0]),
    .occupancy(occ[0]), .drop_cnt(dc0));

  pipe_skid_stage #(.WIDTH(32), .SKID(0), .CNT_W(8)) u1 (
    .clock(clk), .clear(clr), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_data(din[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_data(dout[1]),
    .occupancy(occ[1]), .drop_cnt(dc1));

  pipe_skid_stage #(.WIDTH(32), .SKID(1), .CNT_W(2)) u2 (
    .clock(clk), .clear(clr), .flush(fl[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_data(din[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .out_data(dout[2]),
    .occupancy(occ[2]), .drop_cnt(dc2));

  function automatic int cap(int i);
    return (i == 1) ? 1 : 2;
  endfunction

  function automatic int cmax(int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic logic [7:0] dcv(int i);
    if (i == 0) return dc0;
    if (i == 1) return dc1;
    return {6'b0, dc2};
  endfunction

  // Ready: a two-entry stage takes data while not full (decided from the
  // occupancy at the start of the cycle); a one-entry stage also takes data
  // when its entry leaves in the same cycle.
  function automatic logic mready(int i);
    if (cap(i) == 2) return (mn[i] < 2);
    return (mn[i] == 0) || ordy[i];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ph);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_u%0d_ready", ph, i), 64'(irdy[i]), 64'(mready(i)));
      chk($sformatf("%s_u%0d_valid", ph, i), 64'(ovld[i]), 64'(mn[i] > 0));
      chk($sformatf("%s_u%0d_occ", ph, i), 64'(occ[i]), 64'(mn[i]));
      chk($sformatf("%s_u%0d_drop", ph, i), 64'(dcv(i)), 64'(mc[i]));
      if (mn[i] > 0)
        chk($sformatf("%s_u%0d_data", ph, i), 64'(dout[i]), 64'(md[i][0]));
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      logic r;
      logic acc;
      logic drn;
      r   = mready(i);
      acc = iv[i] && r;
      drn = (mn[i] > 0) && ordy[i];
      if (fl[i]) begin
        mc[i] = mc[i] + mn[i] - int'(drn) + int'(acc);
        if (mc[i] > cmax(i)) mc[i] = cmax(i);
        mn[i] = 0;
      end else begin
        if (drn) begin
          md[i][0] = md[i][1];
          mn[i]--;
        end
        if (acc && mn[i] < 2) begin
          md[i][mn[i]] = din[i];
          mn[i]++;
        end
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1ns later, then
  // the model advances with the rising edge.
  task automatic cycle(string ph);
    #1;
    check_all(ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(int i, logic v, logic [31:0] d, logic r, logic f);
    iv[i] = v; din[i] = d; ordy[i] = r; fl[i] = f;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mn[i] = 0; mc[i] = 0; md[i][0] = 32'h0; md[i][1] = 32'h0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    idle_all();
    model_reset();
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_u%0d_valid", i), 64'(ovld[i]), 64'h0);
      chk($sformatf("reset_u%0d_data", i), 64'(dout[i]), 64'h0);
      chk($sformatf("reset_u%0d_occ", i), 64'(occ[i]), 64'h0);
      chk($sformatf("reset_u%0d_drop", i), 64'(dcv(i)), 64'h0);
    end
    @(negedge clk);
    clr = 1'b0;
    cycle("post_reset");

    // Streaming through the two-entry stage.
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1'b1, 32'(k), 1'b1, 1'b0);
      cycle("stream");
      chk("stream_data", 64'(dout[0]), 64'(k));
      chk("stream_occ", 64'(occ[0]), 64'd1);
      chk("stream_ready", 64'(irdy[0]), 64'd1);
    end
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("stream_end");

    // Backpressure fills main then skid.
    drive(0, 1'b1, 32'hA, 1'b0, 1'b0);
    cycle("bp_a");
    drive(0, 1'b1, 32'hB, 1'b0, 1'b0);
    cycle("bp_b");
    chk("bp_occ", 64'(occ[0]), 64'd2);
    chk("bp_ready", 64'(irdy[0]), 64'd0);
    chk("bp_head", 64'(dout[0]), 64'hA);
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("bp_rel1");
    chk("bp_second", 64'(dout[0]), 64'hB);
    chk("bp_ready_back", 64'(irdy[0]), 64'd1);
    cycle("bp_rel2");
    chk("bp_empty", 64'(ovld[0]), 64'd0);

    // Flush a full stage; in_ready is low so the offered word is not taken.
    drive(0, 1'b1, 32'h11, 1'b0, 1'b0); cycle("ff_fill1");
    drive(0, 1'b1, 32'h22, 1'b0, 1'b0); cycle("ff_fill2");
    drive(0, 1'b1, 32'h33, 1'b0, 1'b1); cycle("ff_flush");
    chk("flush_full_drop", 64'(dc0), 64'd2);
    chk("flush_full_valid", 64'(ovld[0]), 64'd0);

    // One entry held plus a same-cycle accept: two discarded.
    drive(0, 1'b1, 32'h44, 1'b0, 1'b0); cycle("fa_fill");
    drive(0, 1'b1, 32'h55, 1'b0, 1'b1); cycle("fa_flush");
    chk("flush_accept_drop", 64'(dc0), 64'd4);

    // One entry held but drained in the flush cycle: nothing discarded.
    drive(0, 1'b1, 32'h66, 1'b0, 1'b0); cycle("fd_fill");
    drive(0, 1'b0, 32'h0, 1'b1, 1'b1); cycle("fd_flush");
    chk("flush_drain_drop", 64'(dc0), 64'd4);
    chk("flush_drain_occ", 64'(occ[0]), 64'd0);

    // Back-to-back flushes on an empty stage; the second carries an accept.
    drive(0, 1'b0, 32'h0, 1'b0, 1'b1); cycle("bb_flush1");
    chk("bb_empty_drop", 64'(dc0), 64'd4);
    drive(0, 1'b1, 32'h77, 1'b0, 1'b1); cycle("bb_flush2");
    chk("bb_accept_drop", 64'(dc0), 64'd5);
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Saturation of the 2-bit counter.
    for (int r = 0; r < 3; r++) begin
      drive(2, 1'b1, $urandom, 1'b0, 1'b0); cycle("sat_fill1");
      drive(2, 1'b1, $urandom, 1'b0, 1'b0); cycle("sat_fill2");
      drive(2, 1'b0, 32'h0, 1'b0, 1'b1);    cycle("sat_flush");
    end
    chk("sat_drop", 64'(dc2), 64'd3);
    drive(2, 1'b0, 32'h0, 1'b0, 1'b0);

    // Random traffic on all three instances.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++)
        drive(i, 1'(($urandom_range(0, 3)) != 0), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0));
      cycle("rand");
    end
    idle_all();
    cycle("rand_end");

    // Asynchronous clear between edges on the single-entry stage.
    drive(1, 1'b1, 32'h5A5A, 1'b0, 1'b0); cycle("ar_fill");
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("ar_occ_before", 64'(occ[1]), 64'd1);
    #2;
    clr = 1'b1;
    #1;
    chk("ar_valid", 64'(ovld[1]), 64'd0);
    chk("ar_data", 64'(dout[1]), 64'h0);
    chk("ar_occ", 64'(occ[1]), 64'd0);
    chk("ar_drop", 64'(dc1), 64'd0);
    #1;
    clr = 1'b0;
    model_reset();
    @(negedge clk);
    chk("ar_ready", 64'(irdy[1]), 64'd1);
    cycle("ar_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
